// File: rtl/mem_ctrl_if.sv
// Bundle of the IF/MEM request ports and the byte-wide external RAM port of mem_ctrl.
// Requests are accepted at an edge with req=1, rdy=1 and the port's busy bit 0; done pulses last one cycle and have no back-pressure.
interface mem_ctrl_if #(
    parameter int RamAddrWidth = 32
) ();
    logic                    rdy;
    logic                    if_req_in;
    logic [31:0]             if_addr_in;
    logic                    mem_req_in;
    logic                    mem_we_in;
    logic [31:0]             mem_addr_in;
    logic [1:0]              mem_len_in;
    logic [31:0]             mem_wdata_in;
    logic [31:0]             if_inst_out;
    logic                    if_done_out;
    logic [31:0]             mem_rdata_out;
    logic                    mem_done_out;
    logic [1:0]              busy_out;
    logic [7:0]              ram_din;
    logic [7:0]              ram_dout;
    logic [RamAddrWidth-1:0] ram_a;
    logic                    ram_wr;
    logic [1:0]              state_dbg;

    modport slave (
        input  rdy, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_addr_in,
               mem_len_in, mem_wdata_in, ram_din,
        output if_inst_out, if_done_out, mem_rdata_out, mem_done_out, busy_out,
               ram_dout, ram_a, ram_wr, state_dbg
    );

    modport master (
        output rdy, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_addr_in,
               mem_len_in, mem_wdata_in, ram_din,
        input  if_inst_out, if_done_out, mem_rdata_out, mem_done_out, busy_out,
               ram_dout, ram_a, ram_wr, state_dbg
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrating memory controller: latches one IF fetch and one MEM access, runs them
// byte-serially on an 8-bit RAM port (MEM first) and returns little-endian 32-bit results.
module mem_ctrl #(
    parameter int RamAddrWidth = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t                  state;
    logic [31:0]             if_addr_q;
    logic [31:0]             mem_addr_q;
    logic [31:0]             mem_wdata_q;
    logic                    mem_we_q;
    logic [1:0]              mem_len_q;
    logic [1:0]              busy_q;
    logic                    srv_mem;
    logic [31:0]             base_q;
    logic [31:0]             wdata_q;
    logic [2:0]              n_q;
    logic [2:0]              cnt_q;
    logic [31:0]             rbuf_q;
    logic [31:0]             if_inst_q;
    logic [31:0]             mem_rdata_q;
    logic                    if_done_q;
    logic                    mem_done_q;
    logic [RamAddrWidth-1:0] ram_a_q;
    logic [7:0]              ram_dout_q;
    logic                    ram_wr_q;

    logic        if_take, mem_take, if_pend, mem_pend;
    logic [31:0] mem_addr_now, mem_wdata_now, if_addr_now;
    logic        mem_we_now;
    logic [1:0]  mem_len_now;
    logic [1:0]  cap_slot;
    logic [31:0] issue_addr, stall_addr, rd_word;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign if_take       = bus.if_req_in && !busy_q[0];
    assign mem_take      = bus.mem_req_in && !busy_q[1];
    assign if_pend       = busy_q[0] || if_take;
    assign mem_pend      = busy_q[1] || mem_take;
    assign if_addr_now   = busy_q[0] ? if_addr_q   : bus.if_addr_in;
    assign mem_addr_now  = busy_q[1] ? mem_addr_q  : bus.mem_addr_in;
    assign mem_wdata_now = busy_q[1] ? mem_wdata_q : bus.mem_wdata_in;
    assign mem_we_now    = busy_q[1] ? mem_we_q    : bus.mem_we_in;
    assign mem_len_now   = busy_q[1] ? mem_len_q   : bus.mem_len_in;

    // In READ, cnt_q counts active edges: address cnt is issued, byte cnt-2 is captured.
    assign cap_slot   = cnt_q[1:0] - 2'd2;
    assign issue_addr = base_q + {29'b0, cnt_q};
    assign stall_addr = base_q + {30'b0, cap_slot};
    assign rd_word    = rbuf_q | ({24'b0, bus.ram_din} << {cap_slot, 3'b000});

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            if_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_len_q   <= '0;
            busy_q      <= '0;
            srv_mem     <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
        end else if (bus.rdy) begin
            if (if_take) begin
                if_addr_q <= bus.if_addr_in;
                busy_q[0] <= 1'b1;
            end
            if (mem_take) begin
                mem_addr_q  <= bus.mem_addr_in;
                mem_we_q    <= bus.mem_we_in;
                mem_len_q   <= bus.mem_len_in;
                mem_wdata_q <= bus.mem_wdata_in;
                busy_q[1]   <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    // DONE dispatches like IDLE so a waiting request starts at the edge ending DONE.
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                    cnt_q      <= '0;
                    rbuf_q     <= '0;
                    if (mem_pend) begin
                        srv_mem <= 1'b1;
                        base_q  <= mem_addr_now;
                        wdata_q <= mem_wdata_now;
                        n_q     <= len_bytes(mem_len_now);
                        state   <= mem_we_now ? WRITE : READ;
                    end else if (if_pend) begin
                        srv_mem <= 1'b0;
                        base_q  <= if_addr_now;
                        n_q     <= 3'd4;
                        state   <= READ;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q < n_q) ram_a_q <= issue_addr[RamAddrWidth-1:0];
                    else             ram_a_q <= '0;
                    if (cnt_q >= 3'd2) rbuf_q[{cap_slot, 3'b000} +: 8] <= bus.ram_din;
                    if (cnt_q == n_q + 3'd1) begin
                        state <= DONE;
                        if (srv_mem) begin
                            mem_rdata_q <= rd_word;
                            mem_done_q  <= 1'b1;
                            busy_q[1]   <= 1'b0;
                        end else begin
                            if_inst_q <= rd_word;
                            if_done_q <= 1'b1;
                            busy_q[0] <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q < n_q) begin
                        ram_a_q    <= issue_addr[RamAddrWidth-1:0];
                        ram_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        ram_wr_q   <= 1'b1;
                        cnt_q      <= cnt_q + 3'd1;
                    end else begin
                        ram_a_q     <= '0;
                        ram_dout_q  <= '0;
                        ram_wr_q    <= 1'b0;
                        mem_rdata_q <= '0;
                        mem_done_q  <= 1'b1;
                        busy_q[1]   <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // While stalled in READ the address of the next byte to capture is shown, so the RAM
    // output lines up with the capture pipeline on the first edge after rdy returns.
    assign bus.ram_a = (state == READ && !bus.rdy && cnt_q >= 3'd2) ?
                       stall_addr[RamAddrWidth-1:0] : ram_a_q;
    assign bus.ram_wr        = ram_wr_q && bus.rdy;
    assign bus.ram_dout      = ram_dout_q;
    assign bus.if_inst_out   = if_inst_q;
    assign bus.if_done_out   = if_done_q;
    assign bus.mem_rdata_out = mem_rdata_q;
    assign bus.mem_done_out  = mem_done_q;
    assign bus.busy_out      = busy_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-addressed RAM model with one-cycle read latency,
// write log checked against an expected queue, immediate assertions at each check.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    mem_ctrl_if #(.RamAddrWidth(32)) bus ();
    mem_ctrl #(.RamAddrWidth(32)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wr_log [$];
    logic [39:0] exp_q [$];
    int checks = 0;
    int errs = 0;

    function automatic logic [7:0] init_val(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 8'h13;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h12;
            default:       return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_val(a);
    endfunction

    always @(posedge clk_in) begin
        bus.ram_din <= ram_rd(bus.ram_a);
        if (bus.ram_wr) begin
            ram[bus.ram_a] = bus.ram_dout;
            wr_log.push_back({bus.ram_a, bus.ram_dout});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy_out !== 2'b00 || bus.state_dbg !== 2'd0) && n < 40) begin
            cyc();
            n++;
        end
        chk("idle_reached", 64'(n < 40), 64'd1);
    endtask

    task automatic chk_writes(input string tag, input int base_idx);
        int idx;
        logic [39:0] e, o;
        idx = base_idx;
        chk({tag, "_count"}, 64'(wr_log.size() - base_idx), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (idx < wr_log.size()) ? wr_log[idx] : 40'hx;
            chk(tag, 64'(o), 64'(e));
            idx++;
        end
    endtask

    task automatic idle_inputs();
        bus.if_req_in    = 1'b0;
        bus.if_addr_in   = '0;
        bus.mem_req_in   = 1'b0;
        bus.mem_we_in    = 1'b0;
        bus.mem_addr_in  = '0;
        bus.mem_len_in   = '0;
        bus.mem_wdata_in = '0;
    endtask

    task automatic mem_req(input logic we, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd);
        bus.mem_req_in   = 1'b1;
        bus.mem_we_in    = we;
        bus.mem_addr_in  = a;
        bus.mem_len_in   = len;
        bus.mem_wdata_in = wd;
    endtask

    initial begin
        int base;
        rst_in  = 1'b1;
        bus.rdy = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        chk("rst_if_done", 64'(bus.if_done_out), 64'd0);
        chk("rst_mem_done", 64'(bus.mem_done_out), 64'd0);
        chk("rst_busy", 64'(bus.busy_out), 64'd0);
        chk("rst_ram_a", 64'(bus.ram_a), 64'd0);
        chk("rst_ram_wr", 64'(bus.ram_wr), 64'd0);
        chk("rst_ram_dout", 64'(bus.ram_dout), 64'd0);
        chk("rst_inst", 64'(bus.if_inst_out), 64'd0);
        chk("rst_rdata", 64'(bus.mem_rdata_out), 64'd0);
        chk("rst_state", 64'(bus.state_dbg), 64'd0);
        rst_in = 1'b0;
        cyc();

        // Word fetch at 0x4
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h4;
        cyc();
        bus.if_req_in = 1'b0;
        chk("t1_busy_c0", 64'(bus.busy_out), 64'd1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k <= 4) chk("t1_ram_a", 64'(bus.ram_a), 64'(32'h4 + k - 1));
            chk("t1_if_done", 64'(bus.if_done_out), 64'(k == 6));
            if (k == 5) chk("t1_busy_c5", 64'(bus.busy_out), 64'd1);
            if (k == 6) begin
                chk("t1_inst", 64'(bus.if_inst_out), 64'h13);
                chk("t1_busy_c6", 64'(bus.busy_out), 64'd0);
            end
        end

        // Word store then byte load back-to-back
        wait_idle();
        base = wr_log.size();
        exp_q.push_back({32'h100, 8'hEF});
        exp_q.push_back({32'h101, 8'hBE});
        exp_q.push_back({32'h102, 8'hAD});
        exp_q.push_back({32'h103, 8'hDE});
        mem_req(1'b1, 32'h100, 2'b11, 32'hDEADBEEF);
        cyc();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("t2_ram_wr", 64'(bus.ram_wr), 64'(k <= 4));
            if (k <= 4) chk("t2_ram_a", 64'(bus.ram_a), 64'(32'h100 + k - 1));
            chk("t2_mem_done", 64'(bus.mem_done_out), 64'(k == 5));
        end
        mem_req(1'b0, 32'h102, 2'b00, 32'h0);
        cyc();
        idle_inputs();
        chk_writes("t2_write", base);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k == 1) chk("t2_ld_ram_a", 64'(bus.ram_a), 64'h102);
            chk("t2_ld_done", 64'(bus.mem_done_out), 64'(k == 3));
            if (k == 3) chk("t2_ld_rdata", 64'(bus.mem_rdata_out), 64'h0000_00AD);
        end

        // Simultaneous IF and MEM: MEM first
        wait_idle();
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h4;
        mem_req(1'b0, 32'h100, 2'b11, 32'h0);
        cyc();
        idle_inputs();
        chk("t3_busy_c0", 64'(bus.busy_out), 64'd3);
        for (int k = 1; k <= 13; k++) begin
            cyc();
            chk("t3_mem_done", 64'(bus.mem_done_out), 64'(k == 6));
            chk("t3_if_done", 64'(bus.if_done_out), 64'(k == 13));
            if (k < 6) chk("t3_busy_both", 64'(bus.busy_out), 64'd3);
            if (k == 6) begin
                chk("t3_rdata", 64'(bus.mem_rdata_out), 64'hDEAD_BEEF);
                chk("t3_busy_if", 64'(bus.busy_out), 64'd1);
            end
            if (k == 8) chk("t3_if_ram_a", 64'(bus.ram_a), 64'h4);
            if (k == 13) begin
                chk("t3_inst", 64'(bus.if_inst_out), 64'h13);
                chk("t3_busy_end", 64'(bus.busy_out), 64'd0);
            end
        end

        // IF request arriving during a MEM halfword load
        wait_idle();
        mem_req(1'b0, 32'h102, 2'b01, 32'h0);
        cyc();
        idle_inputs();
        chk("t4_busy_c0", 64'(bus.busy_out), 64'd2);
        cyc();
        chk("t4_busy_c1", 64'(bus.busy_out), 64'd2);
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h4;
        cyc();
        bus.if_req_in = 1'b0;
        chk("t4_busy_c2", 64'(bus.busy_out), 64'd3);
        for (int k = 3; k <= 11; k++) begin
            cyc();
            chk("t4_mem_done", 64'(bus.mem_done_out), 64'(k == 4));
            chk("t4_if_done", 64'(bus.if_done_out), 64'(k == 11));
            if (k == 4) begin
                chk("t4_rdata", 64'(bus.mem_rdata_out), 64'h0000_DEAD);
                chk("t4_busy_c4", 64'(bus.busy_out), 64'd1);
            end
            if (k == 6) chk("t4_if_ram_a", 64'(bus.ram_a), 64'h4);
            if (k == 11) chk("t4_inst", 64'(bus.if_inst_out), 64'h13);
        end

        // Halfword load wrapping past 0xFFFFFFFF
        wait_idle();
        mem_req(1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0);
        cyc();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) chk("t5_ram_a0", 64'(bus.ram_a), 64'hFFFF_FFFF);
            if (k == 2) chk("t5_ram_a1", 64'(bus.ram_a), 64'h0);
            chk("t5_done", 64'(bus.mem_done_out), 64'(k == 4));
            if (k == 4) chk("t5_rdata", 64'(bus.mem_rdata_out), 64'h0000_1234);
        end

        // Reset during cycle 2 of a word store
        wait_idle();
        base = wr_log.size();
        exp_q.push_back({32'h200, 8'h44});
        exp_q.push_back({32'h201, 8'h33});
        mem_req(1'b1, 32'h200, 2'b11, 32'h11223344);
        cyc();
        idle_inputs();
        cyc();
        cyc();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        chk("t6_rst_ram_wr", 64'(bus.ram_wr), 64'd0);
        chk("t6_rst_ram_a", 64'(bus.ram_a), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy_out), 64'd0);
        chk("t6_rst_state", 64'(bus.state_dbg), 64'd0);
        for (int k = 4; k <= 9; k++) begin
            cyc();
            chk("t6_no_wr", 64'(bus.ram_wr), 64'd0);
            chk("t6_no_done", 64'(bus.mem_done_out), 64'd0);
        end
        chk_writes("t6_write", base);

        // rdy low for three cycles during a fetch
        wait_idle();
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h100;
        cyc();
        bus.if_req_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 2) bus.rdy = 1'b0;
            if (k == 5) bus.rdy = 1'b1;
            if (k == 4) chk("t7_busy_stall", 64'(bus.busy_out), 64'd1);
            chk("t7_if_done", 64'(bus.if_done_out), 64'(k == 9));
            if (k == 9) chk("t7_inst", 64'(bus.if_inst_out), 64'hDEAD_BEEF);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller on the responder side of the instruction-fetch and data-memory request interfaces. It latches single requests from the IF stage and the MEM stage, arbitrates between them, and runs them as byte-serial transactions on the 8-bit external RAM port. It returns a 32-bit little-endian result with a one-cycle done pulse, and reports per-requester busy status on `busy_out`.

## Interface
- `RamAddrWidth`, 32, width of the byte address driven on `ram_a`.
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; low freezes all state.
- `if_req_in`  in  1  instruction fetch request; sampled only while `busy_out[0]`=0.
- `if_addr_in`  in  32  fetch byte address; always a 4-byte read.
- `mem_req_in`  in  1  data request; sampled only while `busy_out[1]`=0.
- `mem_we_in`  in  1  1 = store, 0 = load.
- `mem_addr_in`  in  32  data byte address.
- `mem_len_in`  in  2  access size: 00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes; 10 is treated as 4 bytes.
- `mem_wdata_in`  in  32  store data; byte k = bits [8k+7:8k].
- `if_inst_out`  out  32  fetched instruction; valid while `if_done_out`=1.
- `if_done_out`  out  1  one-cycle pulse, fetch complete.
- `mem_rdata_out`  out  32  load data, zero-extended; valid while `mem_done_out`=1.
- `mem_done_out`  out  1  one-cycle pulse, load or store complete.
- `busy_out`  out  2  bit0 = IF request latched or in service; bit1 = MEM request latched or in service.
- `ram_din`  in  8  RAM read byte; corresponds to the address presented one cycle earlier.
- `ram_dout`  out  8  RAM write byte.
- `ram_a`  out  RamAddrWidth  RAM byte address.
- `ram_wr`  out  1  1 = write `ram_dout` to `ram_a` this cycle.

## Operation
- Request latching, independent per port:
  - At an edge with `if_req_in`=1 and `busy_out[0]`=0, latch the address and set `busy_out[0]`.
  - MEM uses the same rule with `busy_out[1]`, latching address, `we`, `len` and `wdata`.
  - Latching is allowed while the other port is in service, so `busy_out`=2'b10 still accepts an IF request.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE with one or more requests pending (including those latched at this edge):
  - MEM has priority over IF.
  - A MEM store enters WRITE. A MEM load or an IF fetch enters READ.
  - N = byte count, byte counter = 0.
- READ:
  - Drive `ram_a` = base+k, `ram_wr`=0 for k = 0..N-1.
  - Capture `ram_din` into byte slot k one cycle after address k.
  - After the last byte is captured, go to DONE.
- WRITE:
  - Drive `ram_a` = base+k, `ram_dout` = byte k, `ram_wr`=1 for k = 0..N-1.
  - After byte N-1, go to DONE.
- DONE (one cycle):
  - Assert the done pulse of the served port and clear its busy bit.
  - Return to IDLE; the next pending request starts on the following edge.
- Unused high bytes of `mem_rdata_out` are 0. Sign extension is the MEM stage's job.
- There is no cancellation. A latched fetch always completes for its latched address; discarding stale instructions after a branch is the IF stage's job.
- Address arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFF+1 = 0).

## Timing
- Reset values:
  - all outputs 0; `ram_a`=0, `ram_wr`=0, `busy_out`=2'b00;
  - FSM in IDLE;
  - latched requests cleared.
- Reset mid-transaction aborts it: no further `ram_wr` after the reset edge, and no done pulse.
- Latency, with the accepting edge as edge 0 and cycle n following edge n:
  - Read, N bytes:
    - address k is driven in cycle k+1;
    - byte k is on `ram_din` in cycle k+2;
    - done is high in cycle N+2 (word fetch: cycle 6).
  - Write, N bytes:
    - byte k is written in cycle k+1;
    - done is high in cycle N+1.
- Done pulses last exactly one cycle and are mutually exclusive.
- The busy bit falls at the same edge that raises done.
- Outside READ/WRITE: `ram_wr`=0 and `ram_a`=0.
- `rdy`=0:
  - hold every register;
  - force `ram_wr`=0;
  - ignore requests;
  - when `rdy` returns, resume where stopped. A READ re-presents the current address before capturing.

## Test plan
- Reset, then IF fetch at 0x00000004 with RAM bytes 13,00,00,00 → `ram_a` 4,5,6,7 in cycles 1-4; `if_done_out` high in cycle 6 only, with `if_inst_out`=0x00000013; `busy_out[0]` low from cycle 6.
- MEM store, len 11, addr 0x100, data 0xDEADBEEF → writes EF,BE,AD,DE to 0x100-0x103 in cycles 1-4; `mem_done_out` in cycle 5. A following byte load at 0x102 returns 0x000000AD.
- IF and MEM requests at the same edge → MEM served first and IF second; `busy_out`=2'b11 until MEM done, then 2'b01.
- IF request arriving during a MEM load (`busy_out`=2'b10) → latched, `busy_out`=2'b11; fetch starts the edge after MEM's DONE cycle.
- Halfword load at 0xFFFFFFFF → addresses 0xFFFFFFFF then 0x00000000; high 16 bits of result are 0.
- `rst_in` pulsed during cycle 2 of a word store → only bytes 0-1 written; no done pulse; all outputs 0 next cycle. `rdy` low for 3 cycles mid-fetch → done delayed by exactly 3 cycles with the correct instruction.
